// File: rtl/pcu_fetch.sv
// Program-counter and fetch-request unit: issues sequential fetches over a valid/ready
// channel, pairs in-order responses with their PCs and buffers them for IF/ID.
module pcu_fetch #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h8000_0000,
    parameter int unsigned     INST_BYTES = 4,
    parameter int unsigned     DEPTH      = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_pc,
    input  logic            rsp_valid,
    input  logic [31:0]     rsp_inst,
    output logic            rsp_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst,
    output logic            err
);

    localparam int unsigned     PW         = $clog2(DEPTH);
    localparam int unsigned     CW         = $clog2(DEPTH + 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INST_BYTES - 1);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(INST_BYTES);
    localparam logic [CW:0]     OCC_MAX    = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] r_pc;
    logic            r_pending;
    logic            r_err;

    // Outstanding-request queue: PC of each accepted fetch plus its kill flag.
    logic [XLEN-1:0] r_q_pc   [DEPTH];
    logic            r_q_kill [DEPTH];
    logic [PW-1:0]   r_q_wr;
    logic [PW-1:0]   r_q_rd;
    logic [CW-1:0]   r_inflight;

    logic [XLEN-1:0] r_f_pc   [DEPTH];
    logic [31:0]     r_f_inst [DEPTH];
    logic [PW-1:0]   r_f_wr;
    logic [PW-1:0]   r_f_rd;
    logic [CW-1:0]   r_buf_cnt;

    logic w_credit;
    logic w_accept;
    logic w_rsp;
    logic w_fpush;
    logic w_fpop;

    // Killed entries keep their slot until the response drains them.
    assign w_credit  = ({1'b0, r_inflight} + {1'b0, r_buf_cnt}) < OCC_MAX;
    assign req_valid = rst & ~redirect_valid & (r_pending | (~stall & w_credit));
    assign req_pc    = r_pc;
    assign w_accept  = req_valid & req_ready;

    assign w_rsp     = rsp_valid & (r_inflight != '0);
    assign w_fpush   = w_rsp & ~r_q_kill[r_q_rd] & ~redirect_valid;
    assign out_valid = rst & (r_buf_cnt != '0) & ~redirect_valid;
    assign w_fpop    = out_valid & out_ready;

    assign out_pc    = r_f_pc[r_f_rd];
    assign out_inst  = r_f_inst[r_f_rd];
    assign rsp_ready = 1'b1;
    assign err       = r_err;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order inside the block.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_pending  <= 1'b0;
            r_err      <= 1'b0;
            r_q_wr     <= '0;
            r_q_rd     <= '0;
            r_inflight <= '0;
            r_f_wr     <= '0;
            r_f_rd     <= '0;
            r_buf_cnt  <= '0;
        end else begin
            // req_valid is already low during a redirect, so this also clears on redirect.
            r_pending <= req_valid & ~req_ready;

            if (redirect_valid) begin
                r_pc <= redirect_pc & ALIGN_MASK;
            end else if (w_accept) begin
                r_pc <= r_pc + PC_STEP;
            end

            if (w_accept) begin
                r_q_wr <= r_q_wr + PW'(1);
            end
            if (w_rsp) begin
                r_q_rd <= r_q_rd + PW'(1);
            end
            if (w_accept && !w_rsp) begin
                r_inflight <= r_inflight + CW'(1);
            end else if (!w_accept && w_rsp) begin
                r_inflight <= r_inflight - CW'(1);
            end

            if (rsp_valid && (r_inflight == '0)) begin
                r_err <= 1'b1;
            end

            if (redirect_valid) begin
                r_f_wr    <= '0;
                r_f_rd    <= '0;
                r_buf_cnt <= '0;
            end else begin
                if (w_fpush) begin
                    r_f_wr <= r_f_wr + PW'(1);
                end
                if (w_fpop) begin
                    r_f_rd <= r_f_rd + PW'(1);
                end
                if (w_fpush && !w_fpop) begin
                    r_buf_cnt <= r_buf_cnt + CW'(1);
                end else if (!w_fpush && w_fpop) begin
                    r_buf_cnt <= r_buf_cnt - CW'(1);
                end
            end
        end
    end

    // NOTE: storage arrays carry no reset; occupancy counters and pointers decide which
    // entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_q_pc[r_q_wr]   <= r_pc;
            r_q_kill[r_q_wr] <= 1'b0;
        end
        if (redirect_valid) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_q_kill[i] <= 1'b1;
            end
        end
        if (w_fpush) begin
            r_f_pc[r_f_wr]   <= r_q_pc[r_q_rd];
            r_f_inst[r_f_wr] <= rsp_inst;
        end
    end

endmodule
